// File: rtl/tiny16_uart_tx.sv
// tiny16 UART transmitter: byte FIFO fed by the CPU OUT port, drained as 8N1 frames LSB first.
// TX comes straight from a register so the line never glitches.
`timescale 1ns / 1ps

module tiny16_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 139,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [7:0]                    OUT_DATA,
    input  logic                          OUT_WE,
    output logic                          OUT_READY,
    output logic                          TX,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          OVERRUN
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CntMax = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   Depth  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count;
    logic          full, empty, push, pop;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ovr_q, ovr_d;
    logic          bit_end;

    // Pointers carry one extra wrap bit so full and empty differ.
    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == Depth);
    assign empty   = (count == '0);
    assign push    = OUT_WE & ~full;
    assign bit_end = (cnt_q == CntMax);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= OUT_DATA;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;

        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q[AW-1:0]];
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q[AW-1:0]];
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        ovr_d    = ovr_q | (OUT_WE & full);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ovr_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ovr_q    <= ovr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign OUT_READY  = ~full;
    assign TX         = tx_q;
    assign BUSY       = (state_q != StIdle) || !empty;
    assign FIFO_COUNT = count;
    assign OVERRUN    = ovr_q;

endmodule

// File: tb/tb_tiny16_uart_tx.sv
// Bench for tiny16_uart_tx: a frame-level reference model checked every cycle, a table of
// single-byte frames, and directed burst/overrun/boundary/reset sequences.
`timescale 1ns / 1ps

module tb_tiny16_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] OUT_DATA = 8'h00;
    logic       OUT_WE = 1'b0;
    logic       OUT_READY, TX, BUSY, OVERRUN;
    logic [2:0] FIFO_COUNT;

    always #1 CLK = ~CLK;

    tiny16_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .OUT_DATA   (OUT_DATA),
        .OUT_WE     (OUT_WE),
        .OUT_READY  (OUT_READY),
        .TX         (TX),
        .BUSY       (BUSY),
        .FIFO_COUNT (FIFO_COUNT),
        .OVERRUN    (OVERRUN)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a byte queue plus the position inside the frame being sent.
    logic [7:0] mq[$];
    bit         m_active = 0;
    int         m_pos    = 0;
    logic [7:0] m_cur    = 8'h00;
    bit         m_ovr    = 0;

    function automatic int m_tx();
        int k;
        if (!m_active) return 1;
        k = m_pos / CPB;
        if (k == 0) return 0;
        if (k == 9) return 1;
        return int'(m_cur[k-1]);
    endfunction

    initial begin
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) begin
                mq.delete();
                m_active = 0;
                m_pos    = 0;
                m_ovr    = 0;
            end else begin
                int   sz;
                bit   acc;
                logic [7:0] d;
                sz  = mq.size();
                d   = OUT_DATA;
                acc = OUT_WE && (sz < DEPTH);
                if (OUT_WE && !acc) m_ovr = 1;
                if (m_active && m_pos == FRAME - 1) begin
                    if (sz > 0) begin
                        m_cur = mq.pop_front();
                        m_pos = 0;
                    end else begin
                        m_active = 0;
                    end
                end else if (m_active) begin
                    m_pos++;
                end else if (sz > 0) begin
                    m_cur    = mq.pop_front();
                    m_active = 1;
                    m_pos    = 0;
                end
                if (acc) mq.push_back(d);
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                chk("model_tx", TX, m_tx());
                chk("model_ready", OUT_READY, int'(mq.size() < DEPTH));
                chk("model_count", FIFO_COUNT, mq.size());
                chk("model_busy", BUSY, int'(m_active || mq.size() != 0));
                chk("model_overrun", OVERRUN, int'(m_ovr));
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx"}, TX, 1);
        chk({tag, "_ready"}, OUT_READY, 1);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_count"}, FIFO_COUNT, 0);
        chk({tag, "_overrun"}, OVERRUN, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        OUT_WE = 1'b0;
        #0.5 RST = 1'b0;
        #0.2 chk_reset_outputs("rst_imm");
        repeat (4) @(negedge CLK);
        #0.5 RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic write_byte(input logic [7:0] d);
        OUT_WE   = 1'b1;
        OUT_DATA = d;
        @(negedge CLK);
        OUT_WE   = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int cycles);
        cycles = 0;
        while (BUSY && cycles < limit) begin
            @(negedge CLK);
            cycles++;
        end
        chk("idle_timeout", BUSY, 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] exp_bits;  // bit i = line level at the centre of frame bit i
    } vec_t;

    vec_t vecs[4];

    initial begin
        int c;
        int peak;
        int ones;
        logic [9:0] got;

        vecs[0] = '{data: 8'hA5, exp_bits: 10'b1101001010};
        vecs[1] = '{data: 8'h00, exp_bits: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, exp_bits: 10'b1111111110};
        vecs[3] = '{data: 8'h3C, exp_bits: 10'b1001111000};

        // Power-on reset
        #0.5 RST = 1'b0;
        #1   chk_reset_outputs("por");
        #7   RST = 1'b1;
        chk_en = 1;
        ones = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (TX === 1'b1) ones++;
        end
        chk("idle_tx_high_cycles", ones, 100);

        // Single-byte frames sampled at bit centres
        for (int v = 0; v < 4; v++) begin
            write_byte(vecs[v].data);
            chk("lat_pre_fall", TX, 1);
            @(negedge CLK);
            chk("lat_fall", TX, 0);
            repeat (2) @(negedge CLK);
            got[0] = TX;
            for (int k = 1; k < 10; k++) begin
                repeat (CPB) @(negedge CLK);
                got[k] = TX;
                chk("frame_busy", BUSY, 1);
            end
            chk("frame_bits", int'(got), int'(vecs[v].exp_bits));
            @(negedge CLK);
            chk("frame_last_busy", BUSY, 1);
            @(negedge CLK);
            chk("frame_end_busy", BUSY, 0);
        end

        // Burst of five: one shifting, four queued, back-to-back frames
        do_reset();
        peak = 0;
        for (int i = 0; i < 5; i++) begin
            write_byte(8'(i + 1));
            if (int'(FIFO_COUNT) > peak) peak = FIFO_COUNT;
        end
        chk("burst_ready_full", OUT_READY, 0);
        wait_idle(400, c);
        chk("burst_peak", peak, 4);
        chk("burst_len", c + 3, 5 * FRAME);
        chk("burst_overrun", OVERRUN, 0);

        // Overrun: sixth consecutive write is dropped
        do_reset();
        for (int i = 0; i < 5; i++) write_byte(8'h10 + 8'(i));
        chk("ovr_ready_before", OUT_READY, 0);
        write_byte(8'h99);
        chk("ovr_set", OVERRUN, 1);
        wait_idle(400, c);
        chk("ovr_len", c + 4, 5 * FRAME);
        repeat (20) @(negedge CLK);
        chk("ovr_sticky", OVERRUN, 1);

        // Write lands on the same edge the STOP state pops
        do_reset();
        for (int i = 0; i < 5; i++) write_byte(8'h20 + 8'(i));
        repeat (FRAME - 4) @(negedge CLK);
        chk("bound_count_before", FIFO_COUNT, 4);
        chk("bound_ready_before", OUT_READY, 0);
        chk("bound_stop_tx", TX, 1);
        write_byte(8'hEE);
        chk("bound_count_after", FIFO_COUNT, 3);
        chk("bound_overrun", OVERRUN, 1);
        wait_idle(400, c);

        // Reset in the middle of data bit 3 with a byte still queued
        do_reset();
        write_byte(8'hFF);
        write_byte(8'h00);
        repeat (4 * CPB + 1) @(negedge CLK);
        chk("midrst_count_before", FIFO_COUNT, 1);
        #0.3 RST = 1'b0;
        #0.2 chk_reset_outputs("midrst_imm");
        @(negedge CLK);
        #0.5 RST = 1'b1;
        ones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (TX === 1'b1 && BUSY === 1'b0) ones++;
        end
        chk("midrst_no_residual", ones, 60);

        // Reset while the start bit is low
        write_byte(8'h00);
        @(negedge CLK);
        chk("startrst_low", TX, 0);
        #0.3 RST = 1'b0;
        #0.2 chk("startrst_tx_imm", TX, 1);
        @(negedge CLK);
        #0.5 RST = 1'b1;
        repeat (10) @(negedge CLK);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            OUT_WE   = ($urandom_range(0, 99) < 6);
            OUT_DATA = 8'($urandom);
            @(negedge CLK);
        end
        OUT_WE = 1'b0;
        wait_idle(400, c);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tiny16_uart_tx.md
Name: tiny16_uart_tx

Overview:
- Serial transmitter on the far end of the tiny16 8-bit OUT port.
- The CPU writes bytes with a one-cycle strobe. The block buffers them in a small FIFO and shifts each one out as an 8N1 UART frame, LSB first.
- Gives the core a host-visible output channel without stalling on bit timing.

Parameters:
- CLKS_PER_BIT, 139, CLK cycles per serial bit (16 MHz / 115200). Minimum 2.
- FIFO_DEPTH, 4, byte entries in the transmit FIFO. Must be a power of 2, minimum 2.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-low (0 = reset).
- OUT_DATA  in  8  byte from the CPU output port.
- OUT_WE  in  1  write strobe. OUT_DATA is captured on a rising edge where OUT_WE=1 and OUT_READY=1.
- OUT_READY  out  1  high when the FIFO is not full.
- TX  out  1  serial line; idle high.
- BUSY  out  1  high while a frame is in progress or the FIFO is non-empty.
- FIFO_COUNT  out  clog2(FIFO_DEPTH)+1  number of bytes queued; excludes the byte currently shifting.
- OVERRUN  out  1  sticky flag; set when OUT_WE=1 while OUT_READY=0. Cleared only by reset.

Behaviour:
- Reset (RST=0, asynchronous):
  - TX=1, OUT_READY=1, BUSY=0, FIFO_COUNT=0, OVERRUN=0.
  - State=IDLE; FIFO pointers, shift register and bit timer cleared.
  - All outputs take these values immediately, not at the next edge.
  - Reset asserted mid-frame aborts the frame: TX returns high at once and queued bytes are discarded.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address, so full and empty are distinguishable.
  - full = (count == FIFO_DEPTH). OUT_READY = !full.
  - A write while full is dropped and sets OVERRUN. The FIFO contents are unchanged.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - When full, OUT_READY=0 on that edge, so a write is dropped even if a pop occurs in the same cycle.
- State machine (bit timer cnt counts 0..CLKS_PER_BIT-1; idx is the bit index 0..7):
  - IDLE: TX=1.
    - If the FIFO is non-empty: pop the head into the shift register, cnt=0, go to START.
  - START: TX=0 for CLKS_PER_BIT cycles.
    - At cnt=CLKS_PER_BIT-1: cnt=0, idx=0, go to DATA.
  - DATA: TX=shift[0].
    - At cnt=CLKS_PER_BIT-1: shift right by one, idx+1.
    - After idx=7 completes, go to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles.
    - At cnt=CLKS_PER_BIT-1, if the FIFO is non-empty: pop and go directly to START. There are no idle cycles between back-to-back frames.
    - Otherwise go to IDLE.
- TX is driven from a register, so it never glitches.
- Latency: a write on edge n into an empty FIFO in IDLE is popped on edge n+1, and TX falls after edge n+1. The frame lasts exactly 10*CLKS_PER_BIT cycles from the TX falling edge.
- BUSY = (state != IDLE) || (count != 0).
- Throughput: one byte per 10*CLKS_PER_BIT cycles. Up to FIFO_DEPTH+1 bytes can be accepted back-to-back: FIFO_DEPTH queued plus one shifting.
- Counters never exceed their stated ranges; no wrap states exist beyond pointer wrap modulo 2*FIFO_DEPTH.

Test Plan:
Bench settings: CLKS_PER_BIT=4, FIFO_DEPTH=4, CLK period 2 ns.
- Reset: hold RST=0 for 8 ns and release -> TX=1, OUT_READY=1, BUSY=0, FIFO_COUNT=0, OVERRUN=0. TX stays 1 for 100 cycles with no writes.
- Single byte: write 0xA5 once -> TX falls 1 cycle later. Sampled at bit centres, TX gives 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). Each level lasts 4 cycles, 40 cycles total. BUSY is high throughout, then 0.
- Burst: write 0x01,0x02,0x03,0x04,0x05 on consecutive cycles -> all accepted. FIFO_COUNT peaks at 4. Five frames are emitted with the stop bit followed immediately by the next start bit. Total 200 cycles. OVERRUN=0.
- Overrun: write 6 bytes on consecutive cycles -> the 6th is dropped and OVERRUN=1. Exactly 5 frames are emitted. OVERRUN stays 1 until reset.
- Full boundary: fill the FIFO and assert OUT_WE in the cycle the STOP state pops a byte -> the write is dropped and OVERRUN=1. FIFO_COUNT goes 4 -> 3.
- Mid-frame reset: write 0xFF, then assert RST=0 during DATA bit 3 -> TX=1 immediately (before the next edge). After release, BUSY=0 and FIFO_COUNT=0, and no residual frame is sent.
